// File: rtl/frag_buf_if.sv
// Write/read request bundle between the TLP arbiter, the fragmentation ring
// buffer and the fragmentation engine.
interface frag_buf_if #(
  parameter int LOC_WIDTH  = 128,
  parameter int MAX_WR_LOC = 9,
  parameter int MAX_RD_LOC = 2
);
  localparam int WLW = $clog2(MAX_WR_LOC + 1);
  localparam int RLW = $clog2(MAX_RD_LOC + 1);

  // Handshake: wr_en/rd_en are single-cycle requests with no ready signal.
  // A request is consumed at the clock edge where it is sampled; if it cannot
  // be honoured the buffer pulses wr_err/rd_err on the following cycle instead.
  // rd_valid qualifies rd_data (and tlp_done) one cycle after an accepted read;
  // rd_data holds its last value while rd_valid is low.
  logic                            wr_en;
  logic [WLW-1:0]                  wr_loc;
  logic [MAX_WR_LOC*LOC_WIDTH-1:0] wr_data;
  logic                            wr_last;
  logic                            rd_en;
  logic [RLW-1:0]                  rd_loc;
  logic [MAX_RD_LOC*LOC_WIDTH-1:0] rd_data;
  logic                            rd_valid;
  logic                            tlp_done;

  modport master (
    output wr_en, wr_loc, wr_data, wr_last, rd_en, rd_loc,
    input  rd_data, rd_valid, tlp_done
  );

  modport slave (
    input  wr_en, wr_loc, wr_data, wr_last, rd_en, rd_loc,
    output rd_data, rd_valid, tlp_done
  );
endinterface

// File: rtl/frag_ring_buffer.sv
// Circular staging buffer for TX fragmentation: multi-location writes/reads,
// TLP boundary tracking, full/empty flow control. Define FRAG_BUF_HWM_EN to add hwm.
module frag_ring_buffer #(
  parameter  int LOC_WIDTH  = 128,
  parameter  int DEPTH      = 32,
  parameter  int MAX_WR_LOC = 9,
  parameter  int MAX_RD_LOC = 2,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          flush,
  frag_buf_if.slave     bus,
  output logic [CW-1:0] count,
  output logic [CW-1:0] free,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] tlp_avail,
  output logic          wr_err,
  output logic          rd_err
`ifdef FRAG_BUF_HWM_EN
  ,
  output logic [CW-1:0] hwm
`endif
);

  logic [LOC_WIDTH-1:0]            mem [DEPTH];
  logic [DEPTH-1:0]                last_mark;
  logic [AW-1:0]                   wr_ptr, rd_ptr;
  logic [AW-1:0]                   wr_idx [MAX_WR_LOC];
  logic [AW-1:0]                   rd_idx [MAX_RD_LOC];
  logic                            wr_acc, rd_acc, rd_mark;
  logic [CW-1:0]                   wr_n, rd_n, rd_mark_n, count_next, tlp_next;
  logic [MAX_RD_LOC*LOC_WIDTH-1:0] rd_data_next;

  // Acceptance uses pre-edge free/count, so a same-cycle read never makes room
  // for a write and a same-cycle write is never visible to the read.
  always_comb begin
    wr_n   = CW'(bus.wr_loc);
    rd_n   = CW'(bus.rd_loc);
    wr_acc = !flush && bus.wr_en && (wr_n != '0) && (wr_n <= CW'(MAX_WR_LOC)) && (wr_n <= free);
    rd_acc = !flush && bus.rd_en && (rd_n != '0) && (rd_n <= CW'(MAX_RD_LOC)) && (rd_n <= count);
    for (int k = 0; k < MAX_WR_LOC; k++) begin
      wr_idx[k] = wr_ptr + AW'(k);
    end
    rd_mark      = 1'b0;
    rd_mark_n    = '0;
    rd_data_next = '0;
    for (int j = 0; j < MAX_RD_LOC; j++) begin
      rd_idx[j] = rd_ptr + AW'(j);
      if (CW'(j) < rd_n) begin
        rd_data_next[(MAX_RD_LOC-1-j)*LOC_WIDTH +: LOC_WIDTH] = mem[rd_idx[j]];
        if (last_mark[rd_idx[j]]) begin
          rd_mark   = 1'b1;
          rd_mark_n = rd_mark_n + CW'(1);
        end
      end
    end
    count_next = count + (wr_acc ? wr_n : '0) - (rd_acc ? rd_n : '0);
    tlp_next   = tlp_avail + ((wr_acc && bus.wr_last) ? CW'(1) : '0) - (rd_acc ? rd_mark_n : '0);
  end

  // Storage and end-of-TLP markers are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!arst && wr_acc) begin
      for (int k = 0; k < MAX_WR_LOC; k++) begin
        if (CW'(k) < wr_n) begin
          mem[wr_idx[k]]       <= bus.wr_data[(MAX_WR_LOC-1-k)*LOC_WIDTH +: LOC_WIDTH];
          last_mark[wr_idx[k]] <= bus.wr_last && (CW'(k) == wr_n - CW'(1));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arst || flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      free         <= CW'(DEPTH);
      empty        <= 1'b1;
      full         <= 1'b0;
      tlp_avail    <= '0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      bus.tlp_done <= 1'b0;
      wr_err       <= 1'b0;
      rd_err       <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(bus.wr_loc);
      if (rd_acc) begin
        rd_ptr      <= rd_ptr + AW'(bus.rd_loc);
        bus.rd_data <= rd_data_next;
      end
      bus.rd_valid <= rd_acc;
      bus.tlp_done <= rd_acc && rd_mark;
      count        <= count_next;
      free         <= CW'(DEPTH) - count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == CW'(DEPTH));
      tlp_avail    <= tlp_next;
      wr_err       <= bus.wr_en && !wr_acc;
      rd_err       <= bus.rd_en && !rd_acc;
    end
  end

`ifdef FRAG_BUF_HWM_EN
  // High-water mark survives flush so occupancy history outlives a drop.
  always_ff @(posedge clk) begin
    if (arst) begin
      hwm <= '0;
    end else if (!flush && (count_next > hwm)) begin
      hwm <= count_next;
    end
  end
`endif

endmodule

// File: doc/frag_ring_buffer.md
Name: frag_ring_buffer

Overview:
- Parametrised circular staging buffer for the TX data-fragmentation path. It sits between the TLP arbiter (write side) and the fragmentation engine (read side).
- Accepts 1..MAX_WR_LOC 4DW locations per write cycle and delivers 1..MAX_RD_LOC locations per read cycle.
- Tracks TLP boundaries so the reader knows when a complete TLP is stored and when one has been fully drained.
- Provides true full/empty flow control with wrap-around, replacing the pointer-reset-on-match scheme of the previous generation.

Parameters:
- LOC_WIDTH, 128, bits per location (4DW).
- DEPTH, 32, number of locations; must be a power of two and >= MAX_WR_LOC.
- MAX_WR_LOC, 9, maximum locations written per cycle.
- MAX_RD_LOC, 2, maximum locations read per cycle.
- Derived (localparams):
  - AW = $clog2(DEPTH)
  - CW = $clog2(DEPTH+1)
  - WLW = $clog2(MAX_WR_LOC+1)
  - RLW = $clog2(MAX_RD_LOC+1)

Ports:
- clk  in  1  clock.
- arst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous clear of buffer state.
- wr_en  in  1  write request.
- wr_loc  in  WLW  number of locations to write (1..MAX_WR_LOC).
- wr_data  in  MAX_WR_LOC*LOC_WIDTH  write payload; location 0 is in the MSB slice.
- wr_last  in  1  this write ends a TLP.
- rd_en  in  1  read request.
- rd_loc  in  RLW  number of locations to read (1..MAX_RD_LOC).
- rd_data  out  MAX_RD_LOC*LOC_WIDTH  read payload; location 0 is in the MSB slice.
- rd_valid  out  1  rd_data valid this cycle.
- tlp_done  out  1  pulse, coincident with rd_valid, when the final location of a TLP is delivered.
- count  out  CW  locations stored.
- free  out  CW  DEPTH - count.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- tlp_avail  out  CW  number of complete TLPs stored.
- wr_err  out  1  pulse when a write is rejected.
- rd_err  out  1  pulse when a read is rejected.
- hwm  out  CW  occupancy high-water mark; present only with FRAG_BUF_HWM_EN.

Behaviour:
- Reset (arst=1 at clk edge):
  - wr_ptr=0, rd_ptr=0, count=0, free=DEPTH, empty=1, full=0, tlp_avail=0.
  - rd_data=0, rd_valid=0, tlp_done=0, wr_err=0, rd_err=0, hwm=0.
  - Memory contents and last-marker bits are not reset.
  - Reset overrides flush, wr and rd.
- flush=1 (no reset): same clears as reset except hwm, which is held. Any wr/rd in that cycle is ignored, with no error pulse.
- Write acceptance: wr_en && 1<=wr_loc<=MAX_WR_LOC && wr_loc<=free.
  - free is sampled before the edge; a same-cycle read does not create space.
  - On accept, location k (k<wr_loc) is stored at MEM[(wr_ptr+k) mod DEPTH].
  - wr_ptr advances by wr_loc modulo DEPTH.
  - If wr_last=1, the last-marker bit of location wr_loc-1 is set; all other written locations clear their marker.
  - Otherwise wr_err=1 for one cycle and there is no state change.
- Read acceptance: rd_en && 1<=rd_loc<=MAX_RD_LOC && rd_loc<=count.
  - count is sampled before the edge; a same-cycle write cannot be read.
  - On accept, next cycle: rd_valid=1, and rd_data slot j (j<rd_loc) = MEM[(rd_ptr+j) mod DEPTH]; slots j>=rd_loc are 0.
  - rd_ptr advances by rd_loc modulo DEPTH.
  - tlp_done=1 if any delivered location carries a last marker.
  - Otherwise rd_err=1 for one cycle, rd_valid=0, and rd_data holds its previous value.
- Read latency: 1 cycle. rd_data holds its value when rd_valid=0.
- Counters (registered; count, free, empty, full all update at the same edge):
  - count_next = count + (wr_acc ? wr_loc : 0) - (rd_acc ? rd_loc : 0).
  - tlp_avail: +1 on an accepted write with wr_last=1; -1 when an accepted read includes a last marker; no change when both occur in the same cycle.
  - A single read delivering two last markers (two 1-location TLPs) decrements tlp_avail by 2 but still raises tlp_done only once.
- Wrap-around: multi-location writes and reads that cross index DEPTH-1 continue at index 0 with no gap.
- Simultaneous accepted write and read: both take effect.
  - The read returns data written in earlier cycles only.
  - A write and a read never touch the same location in one cycle, because the read is limited to count.
- Boundaries:
  - full: every write is rejected (wr_err).
  - empty: every read is rejected (rd_err).
  - Exact fill (wr_loc == free) is accepted and makes full=1.
  - Exact drain (rd_loc == count) is accepted and makes empty=1 next cycle.

Optional Feature:
- Macro FRAG_BUF_HWM_EN.
- Defined:
  - Port hwm exists.
  - hwm updates to max(hwm, count_next) every cycle.
  - Cleared by reset only; flush does not clear it.
- Not defined:
  - Port hwm and its register are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then write wr_loc=9 with wr_last=1 -> next cycle count=9, free=23, tlp_avail=1. Then read rd_loc=2 four times and rd_loc=1 once -> the five reads return locations 0..8 in order; tlp_done=1 only with the 1-location read; final count=0, empty=1, tlp_avail=0.
- Fill to 28, then write wr_loc=5 -> wr_err=1, count stays 28. Then write wr_loc=4 -> full=1, count=32. Then read rd_loc=2 -> next cycle count=30.
- Write 9+9+9 and drain 26, then write 9 with wr_last, bringing wr_ptr to 4 and rd_ptr to 26 -> reading 2 locations at a time returns data across indices 30,31,0,1 in order with no corruption.
- With count=3, issue a same-cycle write wr_loc=2 and read rd_loc=2 -> count=3 next cycle, and rd_data equals the two oldest locations.
- rd_en with rd_loc=2 while count=1 -> rd_err=1, rd_valid=0. Then wr_loc=0 with wr_en -> wr_err=1, no pointer movement.
- With count=17, tlp_avail=2 and hwm=17, assert flush -> next cycle count=0, tlp_avail=0, empty=1, and hwm stays 17 (FRAG_BUF_HWM_EN defined). Then assert arst -> hwm=0.
